// File: rtl/frame_sync_detector.sv
// rtl/frame_sync_detector.sv - OFDM frame sync peak detector with backoff, forward and holdoff; FRAME_SYNC_STATS_EN adds stats counters
module frame_sync_detector #(
  parameter int FFT_SIZE     = 1024,
  parameter int CP_SIZE      = 128,
  parameter int METRIC_WIDTH = 32,
  parameter int IDX_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [METRIC_WIDTH-1:0] threshold,
  input  logic [15:0]             backoff,
  input  logic [31:0]             packet_length,
  input  logic [15:0]             holdoff_length,
  input  logic [1:0]              output_select,
  input  logic [METRIC_WIDTH-1:0] m_tdata,
  input  logic                    m_tlast,
  input  logic                    m_tvalid,
  output logic                    m_tready,
  input  logic [31:0]             i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [31:0]             o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    peak_valid,
  output logic [IDX_WIDTH-1:0]    peak_idx,
  output logic [METRIC_WIDTH-1:0] peak_val,
  output logic                    end_of_frame,
  output logic [15:0]             frame_count,
  output logic [15:0]             holdoff_drop_count
);

  typedef enum logic [2:0] {SEARCH, PEAK, BACKOFF, FORWARD, HOLDOFF} state_t;

  localparam logic [15:0]          DEFAULT_BACKOFF = 16'(FFT_SIZE / 2 - CP_SIZE / 2);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE         = IDX_WIDTH'(1);

  state_t                  state, state_d;
  logic [15:0]             cnt, cnt_d;            // backoff countdown, reused as holdoff countdown
  logic [31:0]             fwd_cnt, fwd_cnt_d;    // beats already forwarded in this frame
  logic [METRIC_WIDTH-1:0] max_val, max_val_d;
  logic [IDX_WIDTH-1:0]    max_idx, max_idx_d;
  logic [IDX_WIDTH-1:0]    sample_idx;
  logic [METRIC_WIDTH-1:0] thr_lat, thr_lat_d;
  logic [15:0]             reload_lat, reload_lat_d;
  logic [31:0]             pkt_lat, pkt_lat_d;
  logic [15:0]             hold_lat, hold_lat_d;
  logic                    peak_valid_d;
  logic [IDX_WIDTH-1:0]    peak_idx_d;
  logic [METRIC_WIDTH-1:0] peak_val_d;

  logic        rst, both_valid, beat, fwd_entry, in_frame, last_fwd;
  logic [15:0] backoff_eff;
  logic [31:0] m_data32;

  assign rst         = reset | clear;
  assign both_valid  = i_tvalid & m_tvalid & ~rst;
  assign beat        = both_valid & o_tready;
  assign backoff_eff = (backoff == 16'd0) ? DEFAULT_BACKOFF : backoff;
  // The beat that exhausts the backoff is itself forwarded sample 1.
  assign fwd_entry   = ((state == PEAK) || (state == BACKOFF)) && (cnt == 16'd0);
  assign in_frame    = (state == FORWARD) || fwd_entry;
  assign last_fwd    = in_frame && (fwd_cnt == pkt_lat - 32'd1);

  generate
    if (METRIC_WIDTH >= 32) begin : g_metric_trunc
      assign m_data32 = m_tdata[31:0];
    end else begin : g_metric_ext
      assign m_data32 = {{(32 - METRIC_WIDTH){1'b0}}, m_tdata};
    end
  endgenerate

  // State and datapath registers; reset and clear behave identically
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      cnt        <= 16'd0;
      fwd_cnt    <= 32'd0;
      max_val    <= '0;
      max_idx    <= '0;
      sample_idx <= '0;
      thr_lat    <= '0;
      reload_lat <= 16'd0;
      pkt_lat    <= 32'd0;
      hold_lat   <= 16'd0;
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_val   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      fwd_cnt    <= fwd_cnt_d;
      max_val    <= max_val_d;
      max_idx    <= max_idx_d;
      thr_lat    <= thr_lat_d;
      reload_lat <= reload_lat_d;
      pkt_lat    <= pkt_lat_d;
      hold_lat   <= hold_lat_d;
      peak_valid <= peak_valid_d;
      peak_idx   <= peak_idx_d;
      peak_val   <= peak_val_d;
      if (beat) sample_idx <= sample_idx + IDX_ONE;
    end
  end

  // Next-state logic; config is latched at the SEARCH crossing so mid-frame edits are ignored
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    fwd_cnt_d    = fwd_cnt;
    max_val_d    = max_val;
    max_idx_d    = max_idx;
    thr_lat_d    = thr_lat;
    reload_lat_d = reload_lat;
    pkt_lat_d    = pkt_lat;
    hold_lat_d   = hold_lat;
    peak_valid_d = 1'b0;
    peak_idx_d   = peak_idx;
    peak_val_d   = peak_val;
    if (beat) begin
      case (state)
        SEARCH: begin
          if (m_tdata > threshold) begin
            state_d      = PEAK;
            max_val_d    = m_tdata;
            max_idx_d    = sample_idx;
            cnt_d        = backoff_eff - 16'd1;
            reload_lat_d = backoff_eff - 16'd1;
            thr_lat_d    = threshold;
            pkt_lat_d    = (packet_length == 32'd0) ? 32'd1 : packet_length;
            hold_lat_d   = holdoff_length;
          end
        end
        PEAK, BACKOFF: begin
          if (cnt != 16'd0) begin
            if ((state == PEAK) && (m_tdata > thr_lat) && (m_tdata >= max_val)) begin
              max_val_d = m_tdata;
              max_idx_d = sample_idx;
              cnt_d     = reload_lat;
            end else begin
              cnt_d = cnt - 16'd1;
              if ((state == PEAK) && (m_tdata <= thr_lat)) state_d = BACKOFF;
            end
          end
        end
        HOLDOFF: begin
          if (cnt == 16'd0) state_d = SEARCH;
          else cnt_d = cnt - 16'd1;
        end
        default: ;
      endcase
      if (in_frame) begin
        peak_valid_d = fwd_entry;
        if (fwd_entry) begin
          peak_idx_d = max_idx;
          peak_val_d = max_val;
        end
        if (last_fwd) begin
          fwd_cnt_d = 32'd0;
          if (hold_lat == 16'd0) begin
            state_d = SEARCH;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = hold_lat - 16'd1;
          end
        end else begin
          state_d   = FORWARD;
          fwd_cnt_d = fwd_cnt + 32'd1;
        end
      end
    end
  end

  // Stream handshake and output mux; nothing is presented while reset or clear is high
  always_comb begin
    i_tready     = beat;
    m_tready     = beat;
    end_of_frame = both_valid & last_fwd;
    o_tvalid     = 1'b0;
    o_tdata      = 32'd0;
    o_tlast      = 1'b0;
    case (output_select)
      2'b00: begin
        o_tvalid = both_valid & in_frame;
        o_tdata  = i_tdata;
        o_tlast  = both_valid & (i_tlast | last_fwd);
      end
      2'b01: begin
        o_tvalid = both_valid;
        o_tdata  = in_frame ? i_tdata : 32'd0;
        o_tlast  = both_valid & (i_tlast | last_fwd);
      end
      2'b10: begin
        o_tvalid = both_valid;
        o_tdata  = m_data32;
        o_tlast  = both_valid & m_tlast;
      end
      default: ;
    endcase
  end

`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] frame_cnt_r, drop_cnt_r;

  // Saturating counts of completed frames and above-threshold beats discarded in HOLDOFF
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
      drop_cnt_r  <= 16'd0;
    end else if (beat) begin
      if (last_fwd && (frame_cnt_r != 16'hFFFF)) frame_cnt_r <= frame_cnt_r + 16'd1;
      if ((state == HOLDOFF) && (m_tdata > thr_lat) && (drop_cnt_r != 16'hFFFF))
        drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign frame_count        = frame_cnt_r;
  assign holdoff_drop_count = drop_cnt_r;
`else
  assign frame_count        = 16'd0;
  assign holdoff_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_frame_sync_detector.sv
// tb/tb_frame_sync_detector.sv - self-checking bench for frame_sync_detector
module tb_frame_sync_detector;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] threshold;
  logic [15:0] backoff;
  logic [31:0] packet_length;
  logic [15:0] holdoff_length;
  logic [1:0]  output_select;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid, m_tready;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;
  logic        peak_valid;
  logic [31:0] peak_idx;
  logic [31:0] peak_val;
  logic        end_of_frame;
  logic [15:0] frame_count, holdoff_drop_count;

  always #5 clk = ~clk;

  frame_sync_detector #(.FFT_SIZE(64), .CP_SIZE(16), .METRIC_WIDTH(32), .IDX_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold), .backoff(backoff),
    .packet_length(packet_length), .holdoff_length(holdoff_length), .output_select(output_select),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_val(peak_val),
    .end_of_frame(end_of_frame), .frame_count(frame_count), .holdoff_drop_count(holdoff_drop_count)
  );

  // Scenario record: config, up to three metric spikes, up to two expected frames
  typedef struct {
    int thr; int bo; int pkt; int hold; int mode;
    int a_i; int a_l; int a_v; int b_i; int b_l; int b_v; int c_i; int c_l; int c_v;
    int f0_first; int f0_len; int f0_pidx; int f0_pval;
    int f1_first; int f1_len; int f1_pidx; int f1_pval;
    int drops; int stall_at; int chg; int nbeats;
  } row_t;

  typedef struct { logic [31:0] data; logic last; logic eof; } exp_t;
  typedef struct { int idx; int val; } pk_t;

  exp_t exp_q[$];
  pk_t  pk_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   eof_seen = 0;
  row_t rows[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int metric_of(input row_t r, input int idx);
    if (r.a_l > 0 && idx >= r.a_i && idx < r.a_i + r.a_l) return r.a_v;
    if (r.b_l > 0 && idx >= r.b_i && idx < r.b_i + r.b_l) return r.b_v;
    if (r.c_l > 0 && idx >= r.c_i && idx < r.c_i + r.c_l) return r.c_v;
    return 10;
  endfunction

  function automatic bit in_win(input row_t r, input int idx);
    return (r.f0_len > 0 && idx >= r.f0_first && idx < r.f0_first + r.f0_len) ||
           (r.f1_len > 0 && idx >= r.f1_first && idx < r.f1_first + r.f1_len);
  endfunction

  function automatic bit is_last(input row_t r, input int idx);
    return (r.f0_len > 0 && idx == r.f0_first + r.f0_len - 1) ||
           (r.f1_len > 0 && idx == r.f1_first + r.f1_len - 1);
  endfunction

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0;
    i_tvalid = 1'b1; m_tvalid = 1'b1; o_tready = 1'b1;
    m_tdata = 32'd5000; i_tdata = 32'd0; i_tlast = 1'b0; m_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    pk_q.delete();
    eof_seen = 0;
  endtask

  task automatic push_peaks(input row_t r);
    pk_t p;
    if (r.f0_len > 0) begin p.idx = r.f0_pidx; p.val = r.f0_pval; pk_q.push_back(p); end
    if (r.f1_len > 0) begin p.idx = r.f1_pidx; p.val = r.f1_pval; pk_q.push_back(p); end
  endtask

  // One clock: drive, push expectation on a beat, sample at negedge and compare
  task automatic beat_cycle(input row_t r, input int idx, input bit rdy, input bit clr, input bit post_clr);
    exp_t e;
    pk_t  p;
    bit   fr, lst;
    int   m;
    m   = metric_of(r, idx);
    fr  = in_win(r, idx);
    lst = is_last(r, idx);
    clear = clr;
    i_tvalid = 1'b1; m_tvalid = 1'b1; o_tready = rdy;
    m_tdata = 32'(m); i_tdata = 32'(32'h1000 + idx); i_tlast = 1'b0;
    m_tlast = ((idx % 8) == 7);
    if (rdy && !clr) begin
      e.eof = fr && lst;
      if (r.mode == 0 && fr) begin
        e.data = 32'(32'h1000 + idx); e.last = lst; exp_q.push_back(e);
      end else if (r.mode == 1) begin
        e.data = fr ? 32'(32'h1000 + idx) : 32'd0; e.last = lst; exp_q.push_back(e);
      end else if (r.mode == 2) begin
        e.data = 32'(m); e.last = m_tlast; exp_q.push_back(e);
      end
    end
    @(negedge clk);
    if (!clr) begin
      chk("i_tready", i_tready, rdy);
      chk("m_tready", m_tready, rdy);
      if (o_tvalid && o_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_out: got data %0h at idx %0d, expected no output", o_tdata, idx);
        end else begin
          n_checks--;
          e = exp_q.pop_front();
          chk("o_tdata", o_tdata, e.data);
          chk("o_tlast", o_tlast, e.last);
          chk("end_of_frame", end_of_frame, e.eof);
        end
      end
      if (peak_valid) begin
        n_checks++;
        if (pk_q.size() == 0) begin
          n_errs++;
          $display("FAIL extra_peak_valid: got pulse at idx %0d, expected none", idx);
        end else begin
          n_checks--;
          p = pk_q.pop_front();
          chk("peak_idx", peak_idx, p.idx);
          chk("peak_val", peak_val, p.val);
        end
      end
      if (end_of_frame && i_tready) eof_seen++;
      if (post_clr) begin
        chk("post_clear_o_tvalid", o_tvalid, 0);
        chk("post_clear_o_tlast", o_tlast, 0);
        chk("post_clear_eof", end_of_frame, 0);
      end
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic end_checks(input int nfr, input int drops);
    chk("exp_queue_left", exp_q.size(), 0);
    chk("peak_queue_left", pk_q.size(), 0);
    chk("eof_count", eof_seen, nfr);
`ifdef FRAME_SYNC_STATS_EN
    chk("frame_count", frame_count, nfr);
    chk("holdoff_drop_count", holdoff_drop_count, drops);
`else
    chk("frame_count", frame_count, 0);
    chk("holdoff_drop_count", holdoff_drop_count, 0 * drops);
`endif
  endtask

  task automatic run_row(input row_t r);
    int idx, stalls, cyc, nfr;
    bit rdy;
    do_reset();
    threshold = 32'(r.thr); backoff = 16'(r.bo); packet_length = 32'(r.pkt);
    holdoff_length = 16'(r.hold); output_select = 2'(r.mode);
    push_peaks(r);
    nfr = (r.f0_len > 0 ? 1 : 0) + (r.f1_len > 0 ? 1 : 0);
    idx = 0; stalls = 0; cyc = 0;
    while (idx < r.nbeats && cyc < 2000) begin
      if (r.chg != 0 && idx == r.a_i + 1) begin
        packet_length = 32'd3; backoff = 16'd2; threshold = 32'd600; holdoff_length = 16'd5;
      end
      rdy = !(idx == r.stall_at && stalls < 3);
      if (!rdy) stalls++;
      beat_cycle(r, idx, rdy, 1'b0, 1'b0);
      if (rdy) idx++;
      cyc++;
    end
    chk("row_cycle_budget", (cyc < 2000), 1);
    end_checks(nfr, r.drops);
  endtask

  // Clear lands on forwarded beat 3; a fresh frame is then found from sample index 0
  task automatic clear_seq();
    row_t ra, rb;
    ra = '{100,1,8,0,0, 5,1,600, -1,0,0, -1,0,0, 6,8,5,600, 0,0,0,0, 0,-1,0,0};
    rb = '{100,1,8,0,0, 3,1,700, -1,0,0, -1,0,0, 4,8,3,700, 0,0,0,0, 0,-1,0,0};
    do_reset();
    threshold = 32'd100; backoff = 16'd1; packet_length = 32'd8;
    holdoff_length = 16'd0; output_select = 2'd0;
    push_peaks(ra);
    push_peaks(rb);
    for (int i = 0; i < 8; i++) beat_cycle(ra, i, 1'b1, 1'b0, 1'b0);
    beat_cycle(ra, 8, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) beat_cycle(rb, i, 1'b1, 1'b0, (i == 0));
    end_checks(1, 0);
  endtask

  initial begin
    //         thr  bo pkt hold mode  spike a       spike b       spike c      frame0           frame1        drops stall chg beats
    rows[0] = '{100, 0, 8, 0, 0,  40, 1, 500,  50, 1, 500,  -1, 0, 0,  64, 8, 40, 500,   0, 0, 0, 0,    0,  66, 1, 80};
    rows[1] = '{100, 4, 5, 3, 0,  20,30, 300,  -1, 0, 0,    -1, 0, 0,  53, 5, 49, 300,   0, 0, 0, 0,    0,  -1, 0, 65};
    rows[2] = '{100, 3, 0, 0, 0,  10, 1,1000,  11, 1, 900,  -1, 0, 0,  13, 1, 10,1000,   0, 0, 0, 0,    0,  -1, 0, 20};
    rows[3] = '{100, 2, 3, 0, 1,  10, 1, 200,  11, 1, 300,  -1, 0, 0,  13, 3, 11, 300,   0, 0, 0, 0,    0,  -1, 0, 20};
    rows[4] = '{100, 1, 2, 0, 2,   5, 1, 777,  -1, 0, 0,    -1, 0, 0,   6, 2,  5, 777,   0, 0, 0, 0,    0,  -1, 0, 12};
    rows[5] = '{100, 1, 2,10, 0,   5, 1, 600,  12, 1, 400,  18, 1, 450,  6, 2,  5, 600,  19, 2, 18, 450, 1,  -1, 0, 25};

    reset = 1'b1; clear = 1'b0; threshold = 32'd100; backoff = 16'd0; packet_length = 32'd8;
    holdoff_length = 16'd0; output_select = 2'd0;
    i_tvalid = 1'b1; m_tvalid = 1'b1; o_tready = 1'b1;
    m_tdata = 32'd5000; i_tdata = 32'd0; i_tlast = 1'b0; m_tlast = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_i_tready", i_tready, 0);
    chk("reset_m_tready", m_tready, 0);
    chk("reset_o_tvalid", o_tvalid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; i_tvalid = 1'b0; m_tvalid = 1'b0;
    @(negedge clk);
    chk("reset_peak_valid", peak_valid, 0);
    chk("reset_peak_idx", peak_idx, 0);
    chk("reset_peak_val", peak_val, 0);
    chk("reset_o_tvalid_idle", o_tvalid, 0);
    chk("reset_end_of_frame", end_of_frame, 0);
    chk("reset_frame_count", frame_count, 0);
    chk("reset_drop_count", holdoff_drop_count, 0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) run_row(rows[r]);
    clear_seq();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
